// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM encoding and frame geometry.
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_receiver_rx_brg.sv
// rx_brg: free-running oversample tick generator, one-clk pulse every DIV clocks.
module rx_brg #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int CW      = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt_q;
    assign tick = cnt_q == CW'(DIV - 1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver with 16x oversampling, mid-bit sampling and a
// valid/ready holding register that reports framing errors and overruns.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err
);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [SCW-1:0] SC_MID = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_END = SCW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

    logic tick;
    rx_brg #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_brg (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Both stages preset high so reset never looks like a start bit.
    logic sync_q, rx_s_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            sync_q <= rx_pin;
            rx_s_q <= sync_q;
        end
    end

    state_t                 state_q;
    logic [SCW-1:0]         sc_q;
    logic [BW-1:0]          bit_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   armed_q;
    logic                   frame_err_q;
    logic                   stop_sample, deliver;

    assign stop_sample = tick && state_q == STOP && sc_q == SC_END;
    assign deliver     = stop_sample && rx_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sc_q        <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            armed_q     <= 1'b1;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= stop_sample && !rx_s_q;
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        armed_q <= rx_s_q ? 1'b1 : armed_q;
                        if (armed_q && !rx_s_q) begin
                            state_q <= START;
                            sc_q    <= '0;
                        end
                    end
                    START: begin
                        sc_q <= sc_q + 1'b1;
                        if (sc_q == SC_MID) begin
                            state_q   <= rx_s_q ? IDLE : DATA;
                            sc_q      <= '0;
                            bit_idx_q <= '0;
                        end
                    end
                    DATA: begin
                        sc_q <= sc_q + 1'b1;
                        if (sc_q == SC_END) begin
                            shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                            sc_q      <= '0;
                            bit_idx_q <= bit_idx_q + 1'b1;
                            state_q   <= bit_idx_q == BIT_LAST ? STOP : DATA;
                        end
                    end
                    default: begin
                        sc_q <= sc_q + 1'b1;
                        // A low stop bit disarms until the line goes high again (break).
                        if (sc_q == SC_END) begin
                            state_q <= IDLE;
                            sc_q    <= '0;
                            armed_q <= rx_s_q;
                        end
                    end
                endcase
            end
        end
    end

    logic                 load;
    logic                 rx_valid_d, overrun_d;
    logic [DATA_BITS-1:0] rx_data_d;
    logic                 rx_valid_q, overrun_q;
    logic [DATA_BITS-1:0] rx_data_q;

    always_comb begin
        load       = deliver && (!rx_valid_q || rx_ready);
        rx_valid_d = load || (rx_valid_q && !rx_ready);
        rx_data_d  = load ? shift_q : rx_data_q;
        overrun_d  = deliver && rx_valid_q && !rx_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames at DIV=10 (160 clks per bit) checked against hand-computed results.
module tb_uart_receiver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_pin = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       frame_err;
    logic       overrun_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0, valid_cyc = 0, fe_cyc = 0, ov_cyc = 0, rise_cyc = 0;
    logic [7:0] last_acc = '0;
    logic prev_v = 1'b0;

    uart_receiver #(
        .CLOCK_FREQ(1_600_000),
        .BAUD_RATE (10_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_pin     (rx_pin),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !prev_v) rise_cyc = cyc;
        prev_v = rx_valid;
        if (rx_valid) valid_cyc = valid_cyc + 1;
        if (rx_valid && rx_ready) begin
            acc_cnt  = acc_cnt + 1;
            last_acc = rx_data;
        end
        if (frame_err) fe_cyc = fe_cyc + 1;
        if (overrun_err) ov_cyc = ov_cyc + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int bl, input logic stop_lvl);
        rx_pin = 1'b0;
        step(bl);
        for (int i = 0; i < 8; i++) begin
            rx_pin = d[i];
            step(bl);
        end
        rx_pin = stop_lvl;
        step(bl);
        rx_pin = 1'b1;
    endtask

    initial begin
        int t0, a0, v0, f0, o0;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 32'(rx_valid), 0);
        chk("reset_data", 32'(rx_data), 0);
        chk("reset_frame_err", 32'(frame_err), 0);
        chk("reset_overrun", 32'(overrun_err), 0);
        step(50);

        // 1: single frame
        a0 = acc_cnt; v0 = valid_cyc; f0 = fe_cyc; o0 = ov_cyc;
        t0 = cyc;
        send_frame(8'hA5, 160, 1'b1);
        step(40);
        chk("t1_accepts", 32'(acc_cnt - a0), 1);
        chk("t1_data", 32'(last_acc), 32'hA5);
        chk("t1_valid_width", 32'(valid_cyc - v0), 1);
        chk("t1_latency_ok", 32'(rise_cyc - t0 >= 1500 && rise_cyc - t0 <= 1620), 1);
        chk("t1_frame_err", 32'(fe_cyc - f0), 0);
        chk("t1_overrun", 32'(ov_cyc - o0), 0);

        // 2: overruns while consumer stalls
        rx_ready = 1'b0;
        a0 = acc_cnt; f0 = fe_cyc; o0 = ov_cyc;
        send_frame(8'h00, 160, 1'b1);
        send_frame(8'hFF, 160, 1'b1);
        send_frame(8'h3C, 160, 1'b1);
        step(40);
        @(negedge clk);
        chk("t2_valid_held", 32'(rx_valid), 1);
        chk("t2_data_held", 32'(rx_data), 32'h00);
        chk("t2_overruns", 32'(ov_cyc - o0), 2);
        chk("t2_frame_err", 32'(fe_cyc - f0), 0);
        step(1);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        @(negedge clk);
        chk("t2_valid_cleared", 32'(rx_valid), 0);
        chk("t2_accepted", 32'(last_acc), 32'h00);
        step(1);
        rx_ready = 1'b1;
        step(50);

        // 3: start-bit glitch rejected
        a0 = acc_cnt; f0 = fe_cyc; o0 = ov_cyc;
        rx_pin = 1'b0;
        step(40);
        rx_pin = 1'b1;
        step(300);
        chk("t3_no_byte", 32'(acc_cnt - a0), 0);
        chk("t3_no_errors", 32'((fe_cyc - f0) + (ov_cyc - o0)), 0);
        send_frame(8'h5A, 160, 1'b1);
        step(40);
        chk("t3_data", 32'(last_acc), 32'h5A);
        chk("t3_accepts", 32'(acc_cnt - a0), 1);

        // 4: framing error followed by a break
        a0 = acc_cnt; f0 = fe_cyc;
        send_frame(8'h81, 160, 1'b0);
        rx_pin = 1'b0;
        step(480);
        rx_pin = 1'b1;
        step(320);
        chk("t4_frame_err", 32'(fe_cyc - f0), 1);
        chk("t4_no_byte", 32'(acc_cnt - a0), 0);
        send_frame(8'h42, 160, 1'b1);
        step(40);
        chk("t4_data", 32'(last_acc), 32'h42);
        chk("t4_no_retrigger", 32'(fe_cyc - f0), 1);

        // 5: reset during data bit 4; the sender is reset too and idles the line
        a0 = acc_cnt;
        rx_pin = 1'b0;
        step(160);
        for (int i = 0; i < 4; i++) begin
            rx_pin = 8'h99 >> i;
            step(160);
        end
        rx_pin = 1'b1;
        step(80);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", 32'(rx_valid), 0);
        chk("t5_rst_data", 32'(rx_data), 0);
        chk("t5_rst_errs", 32'({frame_err, overrun_err}), 0);
        step(78 + 4 * 160 + 320);
        chk("t5_no_byte", 32'(acc_cnt - a0), 0);
        send_frame(8'h17, 160, 1'b1);
        step(40);
        chk("t5_data", 32'(last_acc), 32'h17);

        // 6: +/-3% baud error
        f0 = fe_cyc; o0 = ov_cyc;
        send_frame(8'h55, 155, 1'b1);
        step(40);
        chk("t6_fast_data", 32'(last_acc), 32'h55);
        send_frame(8'hAA, 165, 1'b1);
        step(40);
        chk("t6_slow_data", 32'(last_acc), 32'hAA);
        chk("t6_no_errors", 32'((fe_cyc - f0) + (ov_cyc - o0)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
